// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// Latency: n/a (wires only).
// Backpressure: none; start is simply ignored while the block is busy.
//
// Signals:
//   start  - request to begin a subtraction
//   a, b   - minuend / subtrahend, sampled on the edge that accepts start
//   busy   - high while bits are being processed
//   done   - one-cycle pulse, diff/borrow hold the new result
//   diff   - a - b modulo 2^WIDTH
//   borrow - high when a < b (unsigned)
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, one bit per clock, LSB first.
// Latency: WIDTH edges from the edge accepting start to done high.
// Backpressure: start is ignored while busy; back-to-back start is accepted in the DONE cycle.
//
// Ports:
//   clk   - single clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - slave side of serial_subtractor_if (start/a/b in, busy/done/diff/borrow out)
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_subtractor_if.slave   bus
);

    localparam int              CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bin_q, bin_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, done_q;

    // Current bit of the full-subtractor stage and the partial result with it inserted.
    logic             bit_d;
    logic             bit_bout;
    logic [WIDTH-1:0] res_shift;

    always_comb begin
        bit_d    = a_q[0] ^ b_q[0] ^ bin_q;
        bit_bout = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bin_q);
        // New bit enters at the MSB so that after WIDTH shifts bit 0 lands at index 0.
        res_shift            = res_q >> 1;
        res_shift[WIDTH-1]   = bit_d;
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        bin_d    = bin_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = SHIFT;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    bin_d   = 1'b0;
                    cnt_d   = '0;
                    res_d   = '0;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                bin_d = bit_bout;
                res_d = res_shift;
                cnt_d = cnt_q + 1'b1;
                // Visible result only changes on the final bit, so diff never shows partials.
                if (cnt_q == LAST) begin
                    state_d  = DONE;
                    diff_d   = res_shift;
                    borrow_d = bit_bout;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            bin_q    <= 1'b0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            bin_q    <= bin_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            // Status flags registered from next state so outputs come straight from flops.
            busy_q   <= (state_d == SHIFT);
            done_q   <= (state_d == DONE);
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.diff   = diff_q;
    assign bus.borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=1.
// Expected results are queued when an operation is launched and popped on done.
module tb_serial_subtractor;

    logic clk;
    logic rst_n;
    int   cyc;

    serial_subtractor_if #(.WIDTH(8)) bus8 ();
    serial_subtractor_if #(.WIDTH(1)) bus1 ();

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    serial_subtractor #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    typedef struct {
        logic [7:0] d;
        logic       br;
        int         acc;
    } exp_t;

    exp_t q8[$];
    exp_t q1[$];

    int n_cmp;
    int n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- monitors ----------------
    int   bc8, bc1;
    logic pd8, pd1;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            bc8 = 0;
            pd8 = 1'b0;
        end else begin
            if (bus8.busy) bc8++;
            if (bus8.done) begin
                check("w8_done_width", 32'(pd8), 0);
                check("w8_busy_in_done", 32'(bus8.busy), 0);
                check("w8_done_expected", 32'(q8.size() != 0), 1);
                if (q8.size() != 0) begin
                    e = q8.pop_front();
                    check("w8_diff", 32'(bus8.diff), 32'(e.d));
                    check("w8_borrow", 32'(bus8.borrow), 32'(e.br));
                    check("w8_latency", 32'(cyc - e.acc), 8);
                    check("w8_busy_cycles", 32'(bc8), 8);
                end
                bc8 = 0;
            end
            pd8 = bus8.done;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            bc1 = 0;
            pd1 = 1'b0;
        end else begin
            if (bus1.busy) bc1++;
            if (bus1.done) begin
                check("w1_done_width", 32'(pd1), 0);
                check("w1_busy_in_done", 32'(bus1.busy), 0);
                check("w1_done_expected", 32'(q1.size() != 0), 1);
                if (q1.size() != 0) begin
                    e = q1.pop_front();
                    check("w1_diff", 32'(bus1.diff), 32'(e.d[0]));
                    check("w1_borrow", 32'(bus1.borrow), 32'(e.br));
                    check("w1_latency", 32'(cyc - e.acc), 1);
                    check("w1_busy_cycles", 32'(bc1), 1);
                end
                bc1 = 0;
            end
            pd1 = bus1.done;
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called just after a rising edge; the launch edge is the next one.
    function automatic exp_t model8(input logic [7:0] a, input logic [7:0] b, input int acc);
        exp_t e;
        e.d   = 8'(a - b);
        e.br  = (a < b);
        e.acc = acc;
        return e;
    endfunction

    task automatic op8(input logic [7:0] a, input logic [7:0] b);
        bus8.start = 1'b1;
        bus8.a     = a;
        bus8.b     = b;
        q8.push_back(model8(a, b, cyc + 1));
        @(posedge clk); #1;
        bus8.start = 1'b0;
        bus8.a     = 8'($urandom);
        bus8.b     = 8'($urandom);
        repeat (9) @(posedge clk);
        #1;
    endtask

    task automatic op1(input logic a, input logic b);
        exp_t e;
        e.d   = {7'd0, a ^ b};
        e.br  = (!a && b);
        e.acc = cyc + 1;
        bus1.start = 1'b1;
        bus1.a     = a;
        bus1.b     = b;
        q1.push_back(e);
        @(posedge clk); #1;
        bus1.start = 1'b0;
        bus1.a     = 1'($urandom);
        bus1.b     = 1'($urandom);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b1;
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
        bus1.start = 1'b0; bus1.a = '0; bus1.b = '0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(bus8.busy), 0);
        check("rst_done", 32'(bus8.done), 0);
        check("rst_diff", 32'(bus8.diff), 0);
        check("rst_borrow", 32'(bus8.borrow), 0);
        check("rst_w1_diff", 32'(bus1.diff), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic and boundary operands.
        op8(8'h05, 8'h03);
        op8(8'h03, 8'h05);
        op8(8'h00, 8'h01);
        op8(8'hFF, 8'hFF);
        op8(8'h00, 8'h00);
        op8(8'h00, 8'hFF);
        op8(8'h5A, 8'h5A);

        // Back-to-back with start held high; second operands sit on the bus
        // throughout the first SHIFT and must only be taken at the DONE edge.
        bus8.start = 1'b1;
        bus8.a     = 8'h10;
        bus8.b     = 8'h01;
        q8.push_back(model8(8'h10, 8'h01, cyc + 1));
        @(posedge clk); #1;
        bus8.a = 8'h20;
        bus8.b = 8'h02;
        q8.push_back(model8(8'h20, 8'h02, cyc + 9));
        repeat (9) @(posedge clk);
        #1 bus8.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("b2b_drained", 32'(q8.size()), 0);

        // Restart attempt with new operands mid-SHIFT must be ignored.
        bus8.start = 1'b1;
        bus8.a     = 8'h40;
        bus8.b     = 8'h11;
        q8.push_back(model8(8'h40, 8'h11, cyc + 1));
        @(posedge clk); #1;
        bus8.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus8.start = 1'b1;
        bus8.a     = 8'hAA;
        bus8.b     = 8'h55;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("restart_drained", 32'(q8.size()), 0);

        // Reset in the 4th SHIFT cycle, between edges: outputs clear at once, no done.
        bus8.start = 1'b1;
        bus8.a     = 8'h33;
        bus8.b     = 8'h11;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(bus8.busy), 0);
        check("abort_done", 32'(bus8.done), 0);
        check("abort_diff", 32'(bus8.diff), 0);
        check("abort_borrow", 32'(bus8.borrow), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("abort_idle_diff", 32'(bus8.diff), 0);
        op8(8'h80, 8'h7F);

        // Randomized sweep, WIDTH=8.
        for (int i = 0; i < 25; i++) begin
            op8(8'($urandom), 8'($urandom));
        end

        // WIDTH=1: all four operand pairs, then random.
        op1(1'b0, 1'b0);
        op1(1'b0, 1'b1);
        op1(1'b1, 1'b0);
        op1(1'b1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            op1(1'($urandom), 1'($urandom));
        end

        repeat (4) @(posedge clk);
        #1;
        check("w8_all_done", 32'(q8.size()), 0);
        check("w1_all_done", 32'(q1.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
